// File: rtl/cr_iu_vec_pcgen_pkg.sv
// Shared types and constants for the vector-entry PC generator.
// State encodings, default vector-number width and entry-address width.
package cr_iu_vec_pcgen_pkg;

    localparam int VEC_NUM_W_DEF = 5;
    localparam int ENTRY_W       = 30;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_FETCH = 2'b10,
        ST_REDIR = 2'b11
    } pcgen_state_t;

endpackage

// File: rtl/cr_iu_vec_pcgen.sv
// Vector-entry PC generator: table address, handler capture, IFU redirect.
// Optional CR_IU_VEC_ENTRY_LSB_CHK_EN flags fetched entries with bit0 set.
module cr_iu_vec_pcgen
    import cr_iu_vec_pcgen_pkg::*;
#(
    parameter int VEC_NUM_W = VEC_NUM_W_DEF
) (
    input  logic                 misc_clk,
    input  logic                 cpurst_b,
    input  logic                 retire_vector_expt_vld,
    input  logic                 retire_vector_expt_int_hv,
    input  logic [VEC_NUM_W-1:0] retire_pcgen_vec_num,
    input  logic                 vector_pcgen_buf_vbr,
    input  logic [30:0]          vector_pcgen_enter_addr,
    input  logic                 vector_pcgen_ibus_req,
    input  logic                 vector_pcgen_cur_pc_vld,
    input  logic                 vector_pcgen_chgflw_vld,
    input  logic [31:0]          bmu_iu_ibus_rdata,
    input  logic                 ifu_pcgen_chgflw_ready,
    output logic                 pcgen_bmu_vec_req,
    output logic [31:0]          pcgen_bmu_vec_addr,
    output logic                 pcgen_ifu_chgflw_vld,
    output logic [30:0]          pcgen_ifu_chgflw_pc,
    output logic                 pcgen_vector_expt_taken,
    output logic                 pcgen_cp0_vec_misalign
);

    pcgen_state_t         state_q;
    pcgen_state_t         state_n;
    logic [VEC_NUM_W-1:0] vec_num_q;
    logic                 hv_q;
    logic [ENTRY_W-1:0]   entry_word_q;
    logic [ENTRY_W-1:0]   entry_word_n;
    logic [30:0]          target_q;
    logic [30:0]          target_n;
    logic                 latch_evt;
    logic                 load_entry;
    logic                 load_target;
    logic                 rdata_capture;

    // Table entry word: VBR word index plus vector number, wraps mod 2^30
    assign entry_word_n = vector_pcgen_enter_addr[30:1]
                        + ENTRY_W'(vec_num_q);

    // Next-state decode and load enables for the datapath registers
    always_comb begin
        state_n       = state_q;
        latch_evt     = 1'b0;
        load_entry    = 1'b0;
        load_target   = 1'b0;
        rdata_capture = 1'b0;
        target_n      = vector_pcgen_enter_addr;
        unique case (state_q)
            ST_IDLE: begin
                if (retire_vector_expt_vld) begin
                    latch_evt = 1'b1;
                    state_n   = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (hv_q) begin
                    if (vector_pcgen_buf_vbr) begin
                        load_entry = 1'b1;
                        state_n    = ST_FETCH;
                    end
                end else if (vector_pcgen_chgflw_vld) begin
                    load_target = 1'b1;
                    state_n     = ST_REDIR;
                end
            end
            ST_FETCH: begin
                if (vector_pcgen_cur_pc_vld) begin
                    load_target   = 1'b1;
                    rdata_capture = 1'b1;
                    target_n      = bmu_iu_ibus_rdata[31:1];
                    state_n       = ST_REDIR;
                end else if (vector_pcgen_chgflw_vld) begin
                    load_target = 1'b1;
                    state_n     = ST_REDIR;
                end
            end
            ST_REDIR: begin
                if (retire_vector_expt_vld) begin
                    latch_evt = 1'b1;
                    state_n   = ST_ARMED;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register and latched event/address fields
    always_ff @(posedge misc_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q      <= ST_IDLE;
            vec_num_q    <= '0;
            hv_q         <= 1'b0;
            entry_word_q <= '0;
            target_q     <= '0;
        end else begin
            state_q <= state_n;
            if (latch_evt) begin
                vec_num_q <= retire_pcgen_vec_num;
                hv_q      <= retire_vector_expt_int_hv;
            end
            if (load_entry) begin
                entry_word_q <= entry_word_n;
            end
            if (load_target) begin
                target_q <= target_n;
            end
        end
    end

    assign pcgen_bmu_vec_req  = (state_q == ST_FETCH)
                              & vector_pcgen_ibus_req;
    assign pcgen_bmu_vec_addr = {entry_word_q, 2'b00};

    assign pcgen_ifu_chgflw_vld = (state_q == ST_REDIR);
    assign pcgen_ifu_chgflw_pc  = target_q;

    assign pcgen_vector_expt_taken = (state_q == ST_ARMED)
                                   & ~hv_q
                                   & ifu_pcgen_chgflw_ready;

`ifdef CR_IU_VEC_ENTRY_LSB_CHK_EN
    logic misalign_q;

    // Flag an odd handler address; high only during the REDIR cycle
    always_ff @(posedge misc_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= rdata_capture & bmu_iu_ibus_rdata[0];
        end
    end

    assign pcgen_cp0_vec_misalign = misalign_q;
`else
    logic unused_lsb_chk;

    assign unused_lsb_chk = rdata_capture & bmu_iu_ibus_rdata[0];
    assign pcgen_cp0_vec_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_cr_iu_vec_pcgen.sv
// Directed bench for cr_iu_vec_pcgen.
// Build with CR_IU_VEC_ENTRY_LSB_CHK_EN to expect the misalign pulse.
module tb_cr_iu_vec_pcgen;

    logic        misc_clk;
    logic        cpurst_b;
    logic        expt_vld;
    logic        expt_hv;
    logic [4:0]  vec_num;
    logic        buf_vbr;
    logic [30:0] enter_addr;
    logic        ibus_req;
    logic        cur_pc_vld;
    logic        chgflw_in;
    logic [31:0] rdata;
    logic        ifu_ready;
    logic        vec_req;
    logic [31:0] vec_addr;
    logic        chgflw_vld;
    logic [30:0] chgflw_pc;
    logic        expt_taken;
    logic        misalign;

    int n_chk;
    int n_fail;

`ifdef CR_IU_VEC_ENTRY_LSB_CHK_EN
    localparam logic MIS_EXP = 1'b1;
`else
    localparam logic MIS_EXP = 1'b0;
`endif

    cr_iu_vec_pcgen #(.VEC_NUM_W(5)) dut (
        .misc_clk                  (misc_clk),
        .cpurst_b                  (cpurst_b),
        .retire_vector_expt_vld    (expt_vld),
        .retire_vector_expt_int_hv (expt_hv),
        .retire_pcgen_vec_num      (vec_num),
        .vector_pcgen_buf_vbr      (buf_vbr),
        .vector_pcgen_enter_addr   (enter_addr),
        .vector_pcgen_ibus_req     (ibus_req),
        .vector_pcgen_cur_pc_vld   (cur_pc_vld),
        .vector_pcgen_chgflw_vld   (chgflw_in),
        .bmu_iu_ibus_rdata         (rdata),
        .ifu_pcgen_chgflw_ready    (ifu_ready),
        .pcgen_bmu_vec_req         (vec_req),
        .pcgen_bmu_vec_addr        (vec_addr),
        .pcgen_ifu_chgflw_vld      (chgflw_vld),
        .pcgen_ifu_chgflw_pc       (chgflw_pc),
        .pcgen_vector_expt_taken   (expt_taken),
        .pcgen_cp0_vec_misalign    (misalign)
    );

    initial misc_clk = 1'b0;
    always #5 misc_clk = ~misc_clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge misc_clk);
        #1;
    endtask

    task automatic idle_inputs();
        expt_vld   = 1'b0;
        expt_hv    = 1'b0;
        vec_num    = '0;
        buf_vbr    = 1'b0;
        enter_addr = '0;
        ibus_req   = 1'b0;
        cur_pc_vld = 1'b0;
        chgflw_in  = 1'b0;
        rdata      = '0;
        ifu_ready  = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        idle_inputs();
        cpurst_b = 1'b0;
        #12;
        check("rst_req", {31'b0, vec_req}, 32'h0);
        check("rst_addr", vec_addr, 32'h0);
        check("rst_vld", {31'b0, chgflw_vld}, 32'h0);
        check("rst_pc", {1'b0, chgflw_pc}, 32'h0);
        check("rst_taken", {31'b0, expt_taken}, 32'h0);
        check("rst_mis", {31'b0, misalign}, 32'h0);
        cpurst_b = 1'b1;
        tick();

        // idle ignores buf_vbr / cur_pc_vld / chgflw_vld
        buf_vbr = 1'b1; cur_pc_vld = 1'b1; chgflw_in = 1'b1;
        tick();
        idle_inputs();
        check("idle_ign", {31'b0, chgflw_vld}, 32'h0);

        // hardware-vectored entry
        expt_vld = 1'b1; expt_hv = 1'b1; vec_num = 5'd5;
        tick();
        idle_inputs();
        ifu_ready = 1'b1;
        #1 check("hv_taken", {31'b0, expt_taken}, 32'h0);
        buf_vbr = 1'b1; enter_addr = 31'h1000_0000;
        tick();
        idle_inputs();
        check("hv_addr", vec_addr, 32'h2000_0014);
        check("hv_req0", {31'b0, vec_req}, 32'h0);
        ibus_req = 1'b1;
        #1 check("hv_req1", {31'b0, vec_req}, 32'h1);
        tick();
        ibus_req = 1'b0;
        check("hv_hold", vec_addr, 32'h2000_0014);
        cur_pc_vld = 1'b1; chgflw_in = 1'b1;
        rdata = 32'h0000_2468; enter_addr = 31'h0000_5555;
        #1 check("hv_novld", {31'b0, chgflw_vld}, 32'h0);
        tick();
        idle_inputs();
        check("hv_vld", {31'b0, chgflw_vld}, 32'h1);
        check("hv_pc", {1'b0, chgflw_pc}, 32'h0000_1234);
        check("hv_mis", {31'b0, misalign}, 32'h0);
        tick();
        check("hv_pulse", {31'b0, chgflw_vld}, 32'h0);

        // non-vectored entry
        expt_vld = 1'b1; expt_hv = 1'b0; vec_num = 5'd3;
        tick();
        idle_inputs();
        ifu_ready = 1'b1;
        #1 check("nv_taken1", {31'b0, expt_taken}, 32'h1);
        ifu_ready = 1'b0;
        #1 check("nv_taken0", {31'b0, expt_taken}, 32'h0);
        ifu_ready = 1'b1;
        buf_vbr = 1'b1; chgflw_in = 1'b1; enter_addr = 31'h0000_0800;
        tick();
        idle_inputs();
        ifu_ready = 1'b1;
        check("nv_vld", {31'b0, chgflw_vld}, 32'h1);
        check("nv_pc", {1'b0, chgflw_pc}, 32'h0000_0800);
        check("nv_taken_r", {31'b0, expt_taken}, 32'h0);
        tick();
        idle_inputs();

        // vector fetch error path
        expt_vld = 1'b1; expt_hv = 1'b1; vec_num = 5'd2;
        tick();
        idle_inputs();
        buf_vbr = 1'b1; enter_addr = 31'h0000_0100;
        tick();
        idle_inputs();
        check("err_addr", vec_addr, 32'h0000_0208);
        ibus_req = 1'b1; chgflw_in = 1'b1; enter_addr = 31'h0000_4000;
        #1 check("err_req", {31'b0, vec_req}, 32'h1);
        tick();
        idle_inputs();
        ibus_req = 1'b1;
        #1 check("err_req0", {31'b0, vec_req}, 32'h0);
        check("err_vld", {31'b0, chgflw_vld}, 32'h1);
        check("err_pc", {1'b0, chgflw_pc}, 32'h0000_4000);
        tick();
        idle_inputs();

        // wrap-around, odd entry, back-to-back event in REDIR
        expt_vld = 1'b1; expt_hv = 1'b1; vec_num = 5'd31;
        tick();
        idle_inputs();
        buf_vbr = 1'b1; enter_addr = 31'h7FFF_FFFE;
        tick();
        idle_inputs();
        check("wrap_addr", vec_addr, 32'h0000_0078);
        expt_vld = 1'b1; expt_hv = 1'b0;
        tick();
        idle_inputs();
        check("fetch_ign", {31'b0, chgflw_vld}, 32'h0);
        cur_pc_vld = 1'b1; rdata = 32'h0000_1001;
        tick();
        idle_inputs();
        expt_vld = 1'b1; expt_hv = 1'b1; vec_num = 5'd9;
        #1 check("b2b_vld", {31'b0, chgflw_vld}, 32'h1);
        check("b2b_pc", {1'b0, chgflw_pc}, 32'h0000_0800);
        check("mis_pulse", {31'b0, misalign}, {31'b0, MIS_EXP});
        tick();
        idle_inputs();
        ifu_ready = 1'b1;
        #1 check("b2b_vld0", {31'b0, chgflw_vld}, 32'h0);
        check("mis_off", {31'b0, misalign}, 32'h0);
        check("b2b_hv", {31'b0, expt_taken}, 32'h0);
        buf_vbr = 1'b1; enter_addr = 31'h0;
        tick();
        idle_inputs();
        check("b2b_addr", vec_addr, 32'h0000_0024);
        chgflw_in = 1'b1; enter_addr = 31'h0000_0010;
        tick();
        idle_inputs();
        check("b2b_pc2", {1'b0, chgflw_pc}, 32'h0000_0010);
        tick();

        // asynchronous reset while a non-vectored redirect is pending
        expt_vld = 1'b1; expt_hv = 1'b0;
        tick();
        idle_inputs();
        ifu_ready = 1'b1; chgflw_in = 1'b1; enter_addr = 31'h0000_0900;
        #2 cpurst_b = 1'b0;
        #1 check("ar_taken", {31'b0, expt_taken}, 32'h0);
        tick();
        check("ar_vld", {31'b0, chgflw_vld}, 32'h0);
        check("ar_pc", {1'b0, chgflw_pc}, 32'h0);
        idle_inputs();
        cpurst_b = 1'b1;
        tick();
        check("ar_idle", {31'b0, chgflw_vld}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
